// File: rtl/armleosoc_tickgen_pkg.sv
// Shared register map, CTRL bit layout and reset constants for the mtime tick generator.
package armleosoc_tickgen_pkg;

  typedef enum logic [1:0] {
    RegCtrl  = 2'd0,
    RegDiv   = 2'd1,
    RegTicks = 2'd2,
    RegCnt   = 2'd3
  } reg_sel_e;

  localparam logic [31:0] CtrlOffset  = 32'h0;
  localparam logic [31:0] DivOffset   = 32'h4;
  localparam logic [31:0] TicksOffset = 32'h8;
  localparam logic [31:0] CntOffset   = 32'hC;

  localparam int unsigned CtrlEnBit      = 0;
  localparam int unsigned CtrlSrcBit     = 1;
  localparam int unsigned CtrlHaltDbgBit = 2;

  localparam logic [2:0] CtrlRstValue = 3'b000;

  // Per-byte merge of write data into the current register value.
  function automatic logic [31:0] be_merge(input logic [31:0] cur, input logic [31:0] wdata,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : cur[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/armleosoc_mtime_tickgen_sync_edge.sv
// 2-flop synchronizer plus registered rising-edge detector for the external RTC tick.
// Built only when ARMLEOSOC_TICKGEN_EXT_SRC_EN is defined.
`ifdef ARMLEOSOC_TICKGEN_EXT_SRC_EN
module armleosoc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  output logic rise_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    sync1_d = tick_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule
`endif

// File: rtl/armleosoc_mtime_tickgen.sv
// Programmable mtime_increment timebase for the CLINT: prescaled clk or synchronized RTC tick.
// ARMLEOSOC_TICKGEN_EXT_SRC_EN enables the external RTC source (CTRL.SRC); otherwise clk only.
module armleosoc_mtime_tickgen
  import armleosoc_tickgen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DIV_WIDTH   = 32,
  parameter int unsigned TICKS_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write,
  input  logic                  read,
  input  logic [31:0]           write_data,
  input  logic [3:0]            write_byteenable,
  output logic [31:0]           read_data,
  output logic                  address_error,
  input  logic                  rtc_tick,
  input  logic                  debug_halt,
  output logic                  mtime_increment
);

  logic                   en_q, en_d;
  logic                   src_q, src_d;
  logic                   halt_dbg_q, halt_dbg_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [TICKS_WIDTH-1:0] ticks_q, ticks_d;
  logic                   inc_q, inc_d;

  logic [31:0] addr_ext;
  logic        addr_valid;
  reg_sel_e    sel;
  logic        ctrl_we, div_we;
  logic [2:0]  ctrl_wr;
  logic [31:0] div_merged;
  logic        src_wr;
  logic        rtc_event;
  logic        tick_evt;
  logic        active;
  logic        clear;

  // Reads have no side effects, so the strobe is not needed.
  logic unused_read;
  assign unused_read = read;

`ifdef ARMLEOSOC_TICKGEN_EXT_SRC_EN
  armleosoc_sync_edge u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .tick_i (rtc_tick),
    .rise_o (rtc_event)
  );
  assign src_wr = ctrl_wr[CtrlSrcBit];
`else
  logic unused_rtc_tick;
  assign unused_rtc_tick = rtc_tick;
  assign rtc_event       = 1'b0;
  assign src_wr          = 1'b0;
`endif

  assign addr_ext = 32'(address);

  always_comb begin
    sel        = RegCtrl;
    addr_valid = 1'b1;
    case (addr_ext)
      CtrlOffset:  sel = RegCtrl;
      DivOffset:   sel = RegDiv;
      TicksOffset: sel = RegTicks;
      CntOffset:   sel = RegCnt;
      default:     addr_valid = 1'b0;
    endcase
  end

  assign address_error = ~addr_valid;

  always_comb begin
    read_data = '0;
    if (addr_valid) begin
      unique case (sel)
        RegCtrl:  read_data = {29'b0, halt_dbg_q, src_q, en_q};
        RegDiv:   read_data = 32'(div_q);
        RegTicks: read_data = 32'(ticks_q);
        RegCnt:   read_data = 32'(cnt_q);
        default:  read_data = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_we    = write && addr_valid && (sel == RegCtrl);
    div_we     = write && addr_valid && (sel == RegDiv);
    ctrl_wr    = write_byteenable[0] ? write_data[2:0] : {halt_dbg_q, src_q, en_q};
    div_merged = be_merge(32'(div_q), write_data, write_byteenable);

    en_d       = ctrl_we ? ctrl_wr[CtrlEnBit]      : en_q;
    src_d      = ctrl_we ? src_wr                  : src_q;
    halt_dbg_d = ctrl_we ? ctrl_wr[CtrlHaltDbgBit] : halt_dbg_q;
    div_d      = div_we  ? div_merged[DIV_WIDTH-1:0] : div_q;

    // A clearing write beats a coincident event: the event is dropped.
    clear    = div_we || (ctrl_we && ((en_d != en_q) || (src_d != src_q))) || !en_q;
    active   = en_q && !(halt_dbg_q && debug_halt);
    tick_evt = src_q ? rtc_event : 1'b1;

    cnt_d   = cnt_q;
    ticks_d = ticks_q;
    inc_d   = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (active && tick_evt) begin
      if (cnt_q == div_q) begin
        cnt_d   = '0;
        inc_d   = 1'b1;
        ticks_d = ticks_q + TICKS_WIDTH'(1);
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {halt_dbg_q, src_q, en_q} <= CtrlRstValue;
      div_q   <= '0;
      cnt_q   <= '0;
      ticks_q <= '0;
      inc_q   <= 1'b0;
    end else begin
      en_q       <= en_d;
      src_q      <= src_d;
      halt_dbg_q <= halt_dbg_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      ticks_q    <= ticks_d;
      inc_q      <= inc_d;
    end
  end

  assign mtime_increment = inc_q;

endmodule

// File: tb/tb_armleosoc_mtime_tickgen.sv
// Directed bench for armleosoc_mtime_tickgen; RTC-source steps run when
// ARMLEOSOC_TICKGEN_EXT_SRC_EN is defined.
module tb_armleosoc_mtime_tickgen;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic          write;
  logic          read;
  logic [31:0]   write_data;
  logic [3:0]    write_byteenable;
  logic [31:0]   read_data;
  logic          address_error;
  logic          rtc_tick;
  logic          debug_halt;
  logic          mtime_increment;

  int errors = 0;
  int checks = 0;
  int pulses;

  armleosoc_mtime_tickgen #(
    .ADDR_WIDTH  (AW),
    .DIV_WIDTH   (32),
    .TICKS_WIDTH (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .address          (address),
    .write            (write),
    .read             (read),
    .write_data       (write_data),
    .write_byteenable (write_byteenable),
    .read_data        (read_data),
    .address_error    (address_error),
    .rtc_tick         (rtc_tick),
    .debug_halt       (debug_halt),
    .mtime_increment  (mtime_increment)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    address          = a;
    write_data       = d;
    write_byteenable = be;
    write            = 1'b1;
    @(negedge clk);
    write            = 1'b0;
    write_byteenable = 4'h0;
  endtask

  task automatic check_reg(input string tag, input logic [AW-1:0] a, input logic [31:0] expv);
    address = a;
    read    = 1'b1;
    #1;
    check(tag, read_data, expv);
    read    = 1'b0;
  endtask

  task automatic check_inc(input string tag, input logic expv);
    check(tag, {31'b0, mtime_increment}, {31'b0, expv});
  endtask

  initial begin
    rst = 1'b1; address = '0; write = 1'b0; read = 1'b0; write_data = '0;
    write_byteenable = '0; rtc_tick = 1'b0; debug_halt = 1'b0;
    repeat (2) tick();
    check_inc("reset_inc", 1'b0);
    rst = 1'b0;
    check_reg("reset_ctrl", 5'h0, 32'h0);
    check_reg("reset_div", 5'h4, 32'h0);
    check_reg("reset_ticks", 5'h8, 32'h0);
    check_reg("reset_cnt", 5'hC, 32'h0);
    tick();
    address = 5'h10; #1;
    check("err_0x10_flag", {31'b0, address_error}, 32'h1);
    check("err_0x10_data", read_data, 32'h0);
    address = 5'h02; #1;
    check("err_0x2_flag", {31'b0, address_error}, 32'h1);
    check("err_0x2_data", read_data, 32'h0);
    address = 5'h04; #1;
    check("ok_0x4_flag", {31'b0, address_error}, 32'h0);
    tick();

    // DIV=3, clk source: pulse every 4th cycle
    wr(5'h4, 32'd3, 4'hF);
    wr(5'h0, 32'h1, 4'hF);
    check_inc("div3_start_inc", 1'b0);
    check_reg("div3_start_cnt", 5'hC, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_inc("div3_inc", (k % 4) == 0);
      check_reg("div3_cnt", 5'hC, 32'(k % 4));
    end
    check_reg("div3_ticks", 5'h8, 32'd5);

    // DIV=0: output high every cycle
    wr(5'h4, 32'd0, 4'hF);
    check_inc("div0_clear_inc", 1'b0);
    check_reg("div0_clear_ticks", 5'h8, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_inc("div0_inc", 1'b1);
      check_reg("div0_ticks", 5'h8, 32'(5 + k));
    end

    // Halt while CNT=5 with DIV=9
    wr(5'h0, 32'h5, 4'hF);
    check_inc("halt_ctrl_inc", 1'b1);
    wr(5'h4, 32'd9, 4'hF);
    check_inc("halt_div_inc", 1'b0);
    repeat (5) tick();
    check_reg("halt_pre_cnt", 5'hC, 32'd5);
    debug_halt = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_inc("halt_inc", 1'b0);
      check_reg("halt_cnt", 5'hC, 32'd5);
    end
    debug_halt = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_inc("release_inc", k == 5);
    end
    check_reg("release_ticks", 5'h8, 32'd12);
    check_reg("release_cnt", 5'hC, 32'd0);

    // Byte-masked DIV write coinciding with CNT==DIV
    repeat (9) tick();
    check_reg("bew_pre_cnt", 5'hC, 32'd9);
    wr(5'h4, 32'hAABBCC02, 4'b0001);
    check_inc("bew_inc", 1'b0);
    check_reg("bew_cnt", 5'hC, 32'd0);
    check_reg("bew_div", 5'h4, 32'h2);
    check_reg("bew_ticks", 5'h8, 32'd12);
    repeat (2) tick();
    check_reg("bew_mid_cnt", 5'hC, 32'd2);
    tick();
    check_inc("bew_pulse", 1'b1);

    // Asynchronous reset while the pulse is high
    rst = 1'b1;
    #1;
    check_inc("rst_async_inc", 1'b0);
    check_reg("rst_ctrl", 5'h0, 32'h0);
    check_reg("rst_div", 5'h4, 32'h0);
    check_reg("rst_ticks", 5'h8, 32'h0);
    check_reg("rst_cnt", 5'hC, 32'h0);
    tick();
    check_inc("rst_hold_inc", 1'b0);
    rst = 1'b0;
    tick();

    // SRC bit writable only with the external source built
    wr(5'h0, 32'h2, 4'h1);
`ifdef ARMLEOSOC_TICKGEN_EXT_SRC_EN
    check_reg("src_ctrl", 5'h0, 32'h2);
    wr(5'h4, 32'd1, 4'hF);
    wr(5'h0, 32'h3, 4'hF);
    pulses = 0;
    for (int p = 0; p < 4; p++) begin
      rtc_tick = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (c == 3) rtc_tick = 1'b0;
        check_inc("rtc_inc", ((p % 2) == 1) && (c == 4));
        if (mtime_increment) pulses++;
      end
    end
    check("rtc_pulses", 32'(pulses), 32'd2);
    check_reg("rtc_ticks", 5'h8, 32'd2);
`else
    check_reg("src_ctrl", 5'h0, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
